reg_exec_seq: RTL
=================

# reg_exec_seq

Multi-cycle execute sequencer that sits directly upstream of the 8×16 register file (`reg1`) and drives all of its ports. It accepts one 16-bit instruction at a time over a valid/ready handshake and reads two source registers through the register file's read ports. It computes an ALU or iterative-multiply result and writes that result back through the register file's write port, then returns to idle.

## Interface
Parameters:
- none; width 16, register count 8 and opcode map are fixed constants in `reg_exec_pkg`.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  high only in IDLE.
- `instr`  in  16  [15:12] op, [11:9] rd, [8:6] rs_a, [5:3] rs_b, [2:0] ignored.
- `rf_rd_addr_a`, `rf_rd_addr_b`  out  3  register file read addresses.
- `rf_d_out_a`, `rf_d_out_b`  in  16  register file read data, combinational from address.
- `rf_wr`  out  1  register file write enable.
- `rf_wr_addr`  out  3  write address.
- `rf_d_in`  out  16  write data.
- `done`  out  1  one-cycle pulse marking instruction completion.
- `err`  out  1  one-cycle pulse, coincident with `done`, for an illegal opcode.
- `flag_z`, `flag_c`  out  1  zero and carry flags of the last completed legal instruction.

## Operation
Opcodes:
- 0 ADD
- 1 SUB (a−b)
- 2 AND
- 3 OR
- 4 XOR
- 5 NOT a
- 6 SHL1 a
- 7 SHR1 a (logical)
- 8 MOV a
- 9 MUL (low 16 bits of a×b)
- 10–15 illegal.

States: IDLE, READ, EXEC, MUL, WB.
- IDLE: `instr_ready`=1. When `instr_valid`=1, latch op, rd, rs_a and rs_b, then go to READ.
- READ: the read addresses are driven from the latched rs_a and rs_b. At the end of the cycle, sample the read data into op_a and op_b.
  - Illegal opcode → WB.
  - MUL → MUL state.
  - Otherwise → EXEC.
- EXEC: one-cycle combinational ALU; register the result and the carry → WB.
- MUL: 16-iteration shift-add using a 32-bit accumulator, one bit of op_b per cycle, LSB first. Leave after the 16th iteration → WB.
- WB: lasts one cycle, then → IDLE. For a legal opcode, assert `rf_wr`=1 with `rf_wr_addr`=rd and `rf_d_in`=result, and update the flags.
  - For an illegal opcode, `rf_wr` stays 0, the flags hold, and `err` pulses.
  - `done` pulses in every WB cycle.

Width and flag rules:
- All arithmetic is modulo 2^16.
- `flag_z` = (result == 0).
- `flag_c` by opcode:
  - ADD: carry out of bit 15.
  - SUB: borrow, i.e. a < b unsigned.
  - SHL1: a[15].
  - SHR1: a[0].
  - MUL: 1 if product[31:16] ≠ 0.
  - All other opcodes: 0.
- rd equal to rs_a or rs_b is legal. Operands are captured in READ, so writeback cannot corrupt them.

Output hygiene:
- `rf_wr_addr` and `rf_d_in` are 0 whenever `rf_wr`=0.
- Read addresses hold the latched values from READ until the next accept.

## Timing
- Legal non-MUL instruction, accepted at edge T:
  - READ in cycle T+1.
  - EXEC in cycle T+2.
  - WB in cycle T+3, with `rf_wr`/`done` high; the write commits at edge T+4.
  - `instr_ready` is low for 3 cycles, and the next accept is possible at edge T+4.
- MUL: READ, 16 MUL cycles, then WB. `instr_ready` is low for 18 cycles.
- Illegal opcode: READ, then WB. `instr_ready` is low for 2 cycles.
- Back-to-back dependency: a following instruction reading the previous rd sees the new value, because its READ is at T+5.
- `instr_valid` with `instr_ready`=0 is ignored; `instr` is not sampled.
- Reset values, asserted asynchronously:
  - State IDLE, so `instr_ready`=1.
  - `rf_wr`, `rf_wr_addr`, `rf_d_in`, read addresses, `done`, `err`, `flag_z` and `flag_c` all 0.
- Reset mid-operation: the instruction is aborted, no write occurs, and no `done`.

## Structure
- `reg_exec_pkg`:
  - opcode enum
  - state enum
  - instruction field bit positions
  - constants WIDTH=16 and NREGS=8
- Sub-module `mul_iter_16`:
  - inputs: start, a, b
  - outputs: busy, done, prod[31:0]
  - 16-cycle shift-add; the sequencer sits in MUL while busy.
- Everything else lives in `reg_exec_seq`.

## Test plan
- Reset released; R1=5 and R2=7 preloaded; `instr`=ADD rd=3 rs_a=1 rs_b=2 → WB cycle has `rf_wr`=1, addr 3, data 12, z=0, c=0, `done` 1 cycle; total latency 3 cycles.
- SUB with R1=3, R2=5 → data 0xFFFE, c=1; then SUB R1−R1 → data 0, z=1, c=0.
- MUL with R1=0x0100, R2=0x0300 → `instr_ready` low 18 cycles, data 0x0000, c=1; MUL 25×4 → data 100, c=0.
- Opcode 12 → `err`+`done` pulse 2 cycles after accept, `rf_wr` never high, flags unchanged.
- Back-to-back ADD R3=R1+R2 then ADD R4=R3+R3 with `instr_valid` held high → second WB data 24; valid during busy is not accepted.
- `reset` asserted during MUL cycle 8 → all outputs 0 immediately, `instr_ready`=1, no write; the next instruction executes normally.

Source files
------------

// File: rtl/reg_exec_pkg.sv
// Shared constants, opcode/state encodings and instruction field positions
// for the execute sequencer that drives the 8x16 register file.
package reg_exec_pkg;
  localparam int WIDTH = 16;
  localparam int NREGS = 8;
  localparam int AW    = $clog2(NREGS);

  localparam int OP_HI = 15, OP_LO = 12;
  localparam int RD_HI = 11, RD_LO = 9;
  localparam int RA_HI = 8,  RA_LO = 6;
  localparam int RB_HI = 5,  RB_LO = 3;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3, OP_XOR = 4'd4,
    OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7, OP_MOV = 4'd8, OP_MUL = 4'd9
  } op_e;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MUL, S_WB} state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_MUL;
  endfunction
endpackage

// File: rtl/reg_exec_seq_if.sv
// Instruction handshake plus register-file port bundle; master is the sequencer.
interface reg_exec_seq_if import reg_exec_pkg::*; ();
  logic             instr_valid;
  logic             instr_ready;
  logic [WIDTH-1:0] instr;
  logic [AW-1:0]    rf_rd_addr_a, rf_rd_addr_b;
  logic [WIDTH-1:0] rf_d_out_a, rf_d_out_b;
  logic             rf_wr;
  logic [AW-1:0]    rf_wr_addr;
  logic [WIDTH-1:0] rf_d_in;
  logic             done, err, flag_z, flag_c;

  modport master (
    input  instr_valid, instr, rf_d_out_a, rf_d_out_b,
    output instr_ready, rf_rd_addr_a, rf_rd_addr_b, rf_wr, rf_wr_addr, rf_d_in,
           done, err, flag_z, flag_c
  );
  modport slave (
    output instr_valid, instr, rf_d_out_a, rf_d_out_b,
    input  instr_ready, rf_rd_addr_a, rf_rd_addr_b, rf_wr, rf_wr_addr, rf_d_in,
           done, err, flag_z, flag_c
  );
endinterface

// File: rtl/reg_exec_seq_mul_iter_16.sv
// 16-cycle shift-add multiplier, one multiplier bit per cycle, LSB first.
module mul_iter_16 import reg_exec_pkg::*; (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  logic [2*WIDTH-1:0] acc_q, acc_d, mc_q, mc_d;
  logic [WIDTH-1:0]   mp_q, mp_d;
  logic [4:0]         cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    mc_d  = mc_q;
    mp_d  = mp_q;
    cnt_d = cnt_q;
    if (start) begin
      acc_d = '0;
      mc_d  = {{WIDTH{1'b0}}, a};
      mp_d  = b;
      cnt_d = 5'd16;
    end else if (cnt_q != 5'd0) begin
      if (mp_q[0]) acc_d = acc_q + mc_q;
      mc_d  = mc_q << 1;
      mp_d  = mp_q >> 1;
      cnt_d = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      mc_q  <= '0;
      mp_q  <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      mc_q  <= mc_d;
      mp_q  <= mp_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != 5'd0);
  // done marks the cycle whose closing edge performs the final iteration
  assign done = (cnt_q == 5'd1);
  assign prod = acc_q;
endmodule

// File: rtl/reg_exec_seq.sv
// Execute sequencer: accept instruction, read two registers, compute ALU or
// iterative multiply result, write it back, then return to idle.
module reg_exec_seq import reg_exec_pkg::*; (
  input  logic           clk,
  input  logic           reset,
  reg_exec_seq_if.master bus
);
  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [AW-1:0]    rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic             cy_q, cy_d, fz_q, fz_d, fc_q, fc_d;

  logic [WIDTH-1:0]   alu_res, wb_res;
  logic               alu_cy, wb_cy, legal, wr;
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic               unused_ok;

  assign legal     = op_legal(op_q);
  assign mul_start = (state_q == S_READ) && (op_q == OP_MUL);

  // multiplier loads straight from the read ports in the READ cycle
  mul_iter_16 u_mul (
    .clk(clk), .reset(reset), .start(mul_start),
    .a(bus.rf_d_out_a), .b(bus.rf_d_out_b),
    .busy(mul_busy), .done(mul_done), .prod(mul_prod)
  );

  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    case (op_q)
      OP_ADD:  {alu_cy, alu_res} = {1'b0, opa_q} + {1'b0, opb_q};
      OP_SUB:  begin alu_res = opa_q - opb_q; alu_cy = (opa_q < opb_q); end
      OP_AND:  alu_res = opa_q & opb_q;
      OP_OR:   alu_res = opa_q | opb_q;
      OP_XOR:  alu_res = opa_q ^ opb_q;
      OP_NOT:  alu_res = ~opa_q;
      OP_SHL:  begin alu_res = {opa_q[WIDTH-2:0], 1'b0}; alu_cy = opa_q[WIDTH-1]; end
      OP_SHR:  begin alu_res = {1'b0, opa_q[WIDTH-1:1]}; alu_cy = opa_q[0]; end
      OP_MOV:  alu_res = opa_q;
      default: alu_res = '0;
    endcase
  end

  assign wb_res = (op_q == OP_MUL) ? mul_prod[WIDTH-1:0] : res_q;
  assign wb_cy  = (op_q == OP_MUL) ? (|mul_prod[2*WIDTH-1:WIDTH]) : cy_q;
  assign wr     = (state_q == S_WB) && legal;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cy_d    = cy_q;
    fz_d    = fz_q;
    fc_d    = fc_q;
    case (state_q)
      S_IDLE: if (bus.instr_valid) begin
        op_d    = bus.instr[OP_HI:OP_LO];
        rd_d    = bus.instr[RD_HI:RD_LO];
        ra_d    = bus.instr[RA_HI:RA_LO];
        rb_d    = bus.instr[RB_HI:RB_LO];
        state_d = S_READ;
      end
      S_READ: begin
        opa_d = bus.rf_d_out_a;
        opb_d = bus.rf_d_out_b;
        if (!legal)               state_d = S_WB;
        else if (op_q == OP_MUL)  state_d = S_MUL;
        else                      state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_res;
        cy_d    = alu_cy;
        state_d = S_WB;
      end
      S_MUL: if (mul_done) state_d = S_WB;
      S_WB: begin
        if (legal) begin
          fz_d = (wb_res == '0);
          fc_d = wb_cy;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      fz_q    <= fz_d;
      fc_q    <= fc_d;
    end
  end

  assign bus.instr_ready  = (state_q == S_IDLE);
  assign bus.rf_rd_addr_a = ra_q;
  assign bus.rf_rd_addr_b = rb_q;
  assign bus.rf_wr        = wr;
  assign bus.rf_wr_addr   = wr ? rd_q : '0;
  assign bus.rf_d_in      = wr ? wb_res : '0;
  assign bus.done         = (state_q == S_WB);
  assign bus.err          = (state_q == S_WB) && !legal;
  assign bus.flag_z       = fz_q;
  assign bus.flag_c       = fc_q;

  assign unused_ok = ^{bus.instr[2:0], mul_busy};
endmodule
